core_div_unit: RTL and testbench



---
 rtl/core_div_pkg.sv | 25 ++
 rtl/core_div_clz.sv | 21 ++
 rtl/core_div_unit.sv | 189 ++++++++++++++++++
 tb/tb_core_div_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_div_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package core_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   localparam logic [6:0] OPCODE_R = 7'b0110011;

   function automatic logic f3_is_signed(input logic [2:0] f3);
      return (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic f3_is_rem(input logic [2:0] f3);
      return (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

endpackage

// File: rtl/core_div_clz.sv
// Combinational leading-zero counter; returns XLEN for an all-zero input.
module core_div_clz #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]     i_val,
   output logic [$clog2(XLEN):0] o_cnt
);

   localparam int CW = $clog2(XLEN) + 1;

   // Scanning upward lets the highest set bit win.
   always_comb begin
      o_cnt = CW'(XLEN);
      for (int i = 0; i < XLEN; i++) begin
         if (i_val[i]) begin
            o_cnt = CW'(XLEN - 1 - i);
         end
      end
   end

endmodule

// File: rtl/core_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional leading-zero skip is enabled by defining CORE_DIV_EARLY_TERM_EN.
//
//   state | meaning
//   IDLE  | ready for a request; special cases resolve straight to DONE
//   CALC  | one shift/trial-subtract per cycle; last step applies sign fix-up
//   DONE  | result held until the consumer takes it
module core_div_unit
   import core_div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   input  logic [4:0]      i_rd,
   input  logic            i_flush,
   output logic            o_resp_valid,
   input  logic            i_resp_ready,
   output logic [XLEN-1:0] o_result,
   output logic [4:0]      o_rd,
   output logic            o_busy
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvsr_q, dvsr_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      rd_q, rd_d;
   logic            is_rem_q, is_rem_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            resp_valid_q, resp_valid_d;

   logic            req_signed, req_rem;
   logic            dvnd_neg, dvsr_neg;
   logic            div_zero, sgn_ovf;
   logic [XLEN-1:0] abs_dvnd, abs_dvsr, shifted_dvnd;
   logic [CW-1:0]   lz, start_cnt;

   logic [XLEN:0]   trial_shift, trial_diff;
   logic [XLEN-1:0] step_rem, step_quo;
   logic [XLEN-1:0] fix_rem, fix_quo;

   assign req_signed = f3_is_signed(i_funct3);
   assign req_rem    = f3_is_rem(i_funct3);
   assign dvnd_neg   = req_signed & i_dividend[XLEN-1];
   assign dvsr_neg   = req_signed & i_divisor[XLEN-1];
   assign abs_dvnd   = dvnd_neg ? -i_dividend : i_dividend;
   assign abs_dvsr   = dvsr_neg ? -i_divisor  : i_divisor;
   assign div_zero   = (i_divisor == '0);
   assign sgn_ovf    = req_signed & (i_dividend == INT_MIN) & (&i_divisor);

`ifdef CORE_DIV_EARLY_TERM_EN
   core_div_clz #(
      .XLEN (XLEN)
   ) u_clz (
      .i_val (abs_dvnd),
      .o_cnt (lz)
   );
`else
   assign lz = '0;
`endif

   // Leading zeros of the dividend contribute nothing to the remainder, so they are skipped.
   assign start_cnt    = CW'(XLEN) - lz;
   assign shifted_dvnd = abs_dvnd << lz;

   // XLEN+1-bit trial subtraction: MSB of the difference is the borrow.
   assign trial_shift = {rem_q, quo_q[XLEN-1]};
   assign trial_diff  = trial_shift - {1'b0, dvsr_q};
   assign step_rem    = trial_diff[XLEN] ? trial_shift[XLEN-1:0] : trial_diff[XLEN-1:0];
   assign step_quo    = {quo_q[XLEN-2:0], ~trial_diff[XLEN]};
   assign fix_quo     = neg_quo_q ? -step_quo : step_quo;
   assign fix_rem     = neg_rem_q ? -step_rem : step_rem;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      dvsr_d       = dvsr_q;
      result_d     = result_q;
      rd_d         = rd_q;
      is_rem_d     = is_rem_q;
      neg_quo_d    = neg_quo_q;
      neg_rem_d    = neg_rem_q;
      resp_valid_d = resp_valid_q;

      if (i_flush) begin
         state_d      = IDLE;
         resp_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_req_valid) begin
                  rd_d      = i_rd;
                  is_rem_d  = req_rem;
                  neg_quo_d = dvnd_neg ^ dvsr_neg;
                  neg_rem_d = dvnd_neg;
                  dvsr_d    = abs_dvsr;
                  rem_d     = '0;
                  quo_d     = shifted_dvnd;
                  cnt_d     = start_cnt;
                  if (div_zero) begin
                     result_d     = req_rem ? i_dividend : '1;
                     resp_valid_d = 1'b1;
                     state_d      = DONE;
                  end else if (sgn_ovf) begin
                     result_d     = req_rem ? '0 : i_dividend;
                     resp_valid_d = 1'b1;
                     state_d      = DONE;
                  end else if (start_cnt == '0) begin
                     result_d     = '0;
                     resp_valid_d = 1'b1;
                     state_d      = DONE;
                  end else begin
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  result_d     = is_rem_q ? fix_rem : fix_quo;
                  resp_valid_d = 1'b1;
                  state_d      = DONE;
               end
            end
            DONE: begin
               if (i_resp_ready) begin
                  resp_valid_d = 1'b0;
                  state_d      = IDLE;
               end
            end
            default: begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         dvsr_q       <= '0;
         result_q     <= '0;
         rd_q         <= '0;
         is_rem_q     <= 1'b0;
         neg_quo_q    <= 1'b0;
         neg_rem_q    <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         dvsr_q       <= dvsr_d;
         result_q     <= result_d;
         rd_q         <= rd_d;
         is_rem_q     <= is_rem_d;
         neg_quo_q    <= neg_quo_d;
         neg_rem_q    <= neg_rem_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign o_req_ready  = (state_q == IDLE);
   assign o_busy       = (state_q != IDLE);
   assign o_resp_valid = resp_valid_q;
   assign o_result     = result_q;
   assign o_rd         = rd_q;

endmodule

// File: tb/tb_core_div_unit.sv
// Self-checking bench for core_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_core_div_unit;

   localparam int XLEN = 32;
   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;

   logic            clk;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic [4:0]      rd_in;
   logic            flush;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            busy;

   int checks = 0;
   int errors = 0;

   core_div_unit #(.XLEN(XLEN)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_funct3     (funct3),
      .i_dividend   (dividend),
      .i_divisor    (divisor),
      .i_rd         (rd_in),
      .i_flush      (flush),
      .o_resp_valid (resp_valid),
      .i_resp_ready (resp_ready),
      .o_result     (result),
      .o_rd         (rd_out),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics, straight from the ISA rules.
   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (b == 32'd0) return (f3 == F_REM || f3 == F_REMU) ? a : 32'hFFFF_FFFF;
      case (f3)
         F_DIV:   return ovf ? a : 32'(sa / sb);
         F_REM:   return ovf ? 32'd0 : 32'(sa % sb);
         F_REMU:  return a % b;
         default: return a / b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      logic [31:0] mag;
      int z;
      sgn = (f3 == F_DIV) || (f3 == F_REM);
      if (b == 32'd0) return 1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      mag = (sgn && a[31]) ? -a : a;
      z = 0;
`ifdef CORE_DIV_EARLY_TERM_EN
      while (z < XLEN && mag[XLEN-1-z] == 1'b0) z++;
`endif
      return XLEN - z + 1;
   endfunction

   task automatic wait_resp(output int lat);
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
      int lat;
      @(negedge clk);
      check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; funct3 = f3; dividend = a; divisor = b; rd_in = rd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_resp(lat);
      check_val({tag, "_lat"}, 32'(lat), 32'(ref_lat(f3, a, b)));
      check_val({tag, "_res"}, result, exp);
      check_val({tag, "_rd"}, 32'(rd_out), 32'(rd));
      @(posedge clk); #1;
      check_val({tag, "_drop"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      int lat;
      logic seen;
      logic [2:0] f3;
      logic [31:0] a, b;

      rst = 1'b1; req_valid = 1'b0; funct3 = F_DIVU; dividend = '0; divisor = '0;
      rd_in = '0; flush = 1'b0; resp_ready = 1'b1;
      #2;
      check_val("rst_valid", 32'(resp_valid), 32'd0);
      check_val("rst_result", result, 32'd0);
      check_val("rst_rd", 32'(rd_out), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_ready", 32'(req_ready), 32'd1);
      @(negedge clk); rst = 1'b0;

      run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 5'd1, 32'd14);
      run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 5'd2, 32'd2);
      run_op("div_m20_3", F_DIV, 32'hFFFF_FFEC, 32'd3, 5'd3, 32'hFFFF_FFFA);
      run_op("rem_m20_3", F_REM, 32'hFFFF_FFEC, 32'd3, 5'd4, 32'hFFFF_FFFE);
      run_op("rem_20_m3", F_REM, 32'd20, 32'hFFFF_FFFD, 5'd5, 32'd2);
      run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000);
      run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0);
      run_op("divu_5_0", F_DIVU, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
      run_op("remu_5_0", F_REMU, 32'd5, 32'd0, 5'd9, 32'd5);
      run_op("divu_1_1", F_DIVU, 32'd1, 32'd1, 5'd10, 32'd1);
      run_op("div_0_m3", F_DIV, 32'd0, 32'hFFFF_FFFD, 5'd11, 32'd0);

      // consumer stalls in DONE while a new request is waiting
      @(negedge clk);
      resp_ready = 1'b0; req_valid = 1'b1; funct3 = F_DIVU; dividend = 32'd1000; divisor = 32'd7; rd_in = 5'd21;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_resp(lat);
      check_val("hold_res0", result, 32'd142);
      @(negedge clk);
      req_valid = 1'b1; dividend = 32'd50; divisor = 32'd5; rd_in = 5'd7;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check_val("hold_res", result, 32'd142);
         check_val("hold_rd", 32'(rd_out), 32'd21);
         check_val("hold_ready", 32'(req_ready), 32'd0);
         check_val("hold_valid", 32'(resp_valid), 32'd1);
      end
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1;
      check_val("hold_exit_valid", 32'(resp_valid), 32'd0);
      check_val("hold_exit_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check_val("hold_next_accept", 32'(busy), 32'd1);
      req_valid = 1'b0;
      wait_resp(lat);
      check_val("hold_next_res", result, 32'd10);
      check_val("hold_next_rd", 32'(rd_out), 32'd7);
      @(posedge clk); #1;

      // flush during CALC
      @(negedge clk);
      req_valid = 1'b1; funct3 = F_DIVU; dividend = 32'hFFFF_FFF0; divisor = 32'd3; rd_in = 5'd5;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1;
      check_val("flush_busy", 32'(busy), 32'd0);
      check_val("flush_ready", 32'(req_ready), 32'd1);
      @(negedge clk); flush = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      check_val("flush_no_resp", 32'(seen), 32'd0);

      // flush beats a same-cycle handshake in IDLE
      @(negedge clk); req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      check_val("flush_idle_block", 32'(busy), 32'd0);
      @(negedge clk); req_valid = 1'b0; flush = 1'b0;
      run_op("post_flush", F_DIVU, 32'd9, 32'd3, 5'd13, 32'd3);

      // asynchronous reset mid-CALC
      @(negedge clk);
      req_valid = 1'b1; funct3 = F_DIVU; dividend = 32'd1000; divisor = 32'd3; rd_in = 5'd9;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      check_val("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1; #1;
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_ready", 32'(req_ready), 32'd1);
      check_val("arst_valid", 32'(resp_valid), 32'd0);
      check_val("arst_result", result, 32'd0);
      check_val("arst_rd", 32'(rd_out), 32'd0);
      @(negedge clk); rst = 1'b0;

      for (int n = 0; n < 300; n++) begin
         f3 = 3'b100 | 3'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'($urandom_range(0, 255));
            4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 14));
            5: a = a >> $urandom_range(0, 31);
            6: a = 32'd0;
            default: ;
         endcase
         run_op("rnd", f3, a, b, 5'($urandom), ref_res(f3, a, b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
